// File: rtl/glitch_sequencer.sv
// Command-driven glitch sequencer. Parses UART command bytes, times an active-low glitch
// pulse from a target trigger or a command, pulses target reset, and queues response bytes.
module glitch_sequencer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_CYCLES = 36000000,
    parameter int unsigned TIMEOUT    = 72000000,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       trigger_in,
    output logic       glitch_n,
    output logic       target_rst_n,
    output logic       armed,
    output logic       busy
);

    localparam int unsigned      AW       = $clog2(RSP_DEPTH);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [AW:0]      DEPTH    = (AW + 1)'(RSP_DEPTH);

    localparam logic [7:0] CMD_D = 8'h44, CMD_W = 8'h57, CMD_A = 8'h41;
    localparam logic [7:0] CMD_F = 8'h46, CMD_R = 8'h52, CMD_X = 8'h58;
    localparam logic [7:0] RSP_UNK = 8'h3F, RSP_BUSY = 8'h42, RSP_TO = 8'h54;
    localparam logic [7:0] RSP_GLITCH = 8'h47, RSP_RST = 8'h72;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_DELAY, S_GLITCH, S_TRST} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [1:0]       ld_cnt_q, ld_cnt_d;
    logic             ld_width_q, ld_width_d;
    logic             trig_s1_q, trig_s2_q, trig_prev_q;
    logic             glitch_n_q, target_rst_n_q;
    logic             fire, trig_edge;

    logic             push0, push1, acc0, acc1, pop;
    logic [7:0]       push0_data, push1_data;
    logic [7:0]       rsp_mem_q [RSP_DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      rsp_cnt_q, rsp_free;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;

    assign trig_edge = trig_s2_q & ~trig_prev_q;

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        width_d    = width_q;
        ld_cnt_d   = ld_cnt_q;
        ld_width_d = ld_width_q;
        push0      = 1'b0;
        push0_data = '0;
        push1      = 1'b0;
        push1_data = '0;
        fire       = 1'b0;

        case (state_q)
            S_IDLE: if (rx_valid) begin
                push0      = 1'b1;
                push0_data = rx_data;
                case (rx_data)
                    CMD_D, CMD_W: begin
                        state_d    = S_LOAD;
                        ld_cnt_d   = '0;
                        ld_width_d = (rx_data == CMD_W);
                        push0      = 1'b0;
                    end
                    CMD_A:   state_d = S_ARMED;
                    CMD_F:   fire = 1'b1;
                    CMD_R:   state_d = S_TRST;
                    CMD_X:   begin end
                    default: push0_data = RSP_UNK;
                endcase
            end
            S_LOAD: if (rx_valid) begin
                if (ld_width_q) width_d = {width_q[CNT_W-9:0], rx_data};
                else            delay_d = {delay_q[CNT_W-9:0], rx_data};
                ld_cnt_d = ld_cnt_q + 2'd1;
                if (ld_cnt_q == 2'd3) begin
                    state_d    = S_IDLE;
                    push0      = 1'b1;
                    push0_data = ld_width_q ? CMD_W : CMD_D;
                end
            end
            S_ARMED: begin
                if (trig_edge) begin
                    fire = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    push0      = 1'b1;
                    push0_data = RSP_TO;
                end
            end
            S_DELAY: if (cnt_q == delay_q - CNT_W'(1)) state_d = S_GLITCH;
            S_GLITCH: begin
                // A zero width passes through GLITCH for one cycle with glitch_n held high.
                if (width_q == '0 || cnt_q == width_q - CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    push0      = 1'b1;
                    push0_data = RSP_GLITCH;
                end
            end
            S_TRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d    = S_IDLE;
                    push0      = 1'b1;
                    push0_data = RSP_RST;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) state_d = (delay_q == '0) ? S_GLITCH : S_DELAY;

        // Abort overrides any completion or trigger in the same cycle; other bytes just answer 'B'.
        if (rx_valid && (state_q inside {S_ARMED, S_DELAY, S_GLITCH, S_TRST})) begin
            if (rx_data == CMD_X) begin
                state_d    = S_IDLE;
                push0      = 1'b1;
                push0_data = CMD_X;
            end else begin
                push1      = 1'b1;
                push1_data = RSP_BUSY;
            end
        end

        cnt_d = (state_d != state_q || state_d == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    end

    // Up to two responses may be decided in one cycle; each takes a slot only if one is free.
    assign pop      = (rsp_cnt_q != '0) && !tx_busy && !tx_start_q;
    assign rsp_free = DEPTH - rsp_cnt_q + (AW + 1)'(pop);
    assign acc0     = push0 && (rsp_free != '0);
    assign acc1     = push1 && (rsp_free > (AW + 1)'(acc0));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            delay_q        <= '0;
            width_q        <= '0;
            ld_cnt_q       <= '0;
            ld_width_q     <= 1'b0;
            trig_s1_q      <= 1'b0;
            trig_s2_q      <= 1'b0;
            trig_prev_q    <= 1'b0;
            glitch_n_q     <= 1'b1;
            target_rst_n_q <= 1'b1;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rsp_cnt_q      <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            delay_q        <= delay_d;
            width_q        <= width_d;
            ld_cnt_q       <= ld_cnt_d;
            ld_width_q     <= ld_width_d;
            trig_s1_q      <= trigger_in;
            trig_s2_q      <= trig_s1_q;
            trig_prev_q    <= trig_s2_q;
            glitch_n_q     <= !(state_d == S_GLITCH && width_q != '0);
            target_rst_n_q <= (state_d != S_TRST);
            rd_ptr_q       <= rd_ptr_q + AW'(pop);
            wr_ptr_q       <= wr_ptr_q + AW'(acc0) + AW'(acc1);
            rsp_cnt_q      <= rsp_cnt_q + (AW + 1)'(acc0) + (AW + 1)'(acc1) - (AW + 1)'(pop);
            tx_start_q     <= pop;
            if (pop) tx_data_q <= rsp_mem_q[rd_ptr_q];
        end
    end

    // NOTE: response storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (acc0) rsp_mem_q[wr_ptr_q] <= push0_data;
        if (acc1) rsp_mem_q[wr_ptr_q + AW'(acc0)] <= push1_data;
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign glitch_n     = glitch_n_q;
    assign target_rst_n = target_rst_n_q;
    assign armed        = (state_q == S_ARMED);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: response bytes and pulse windows are
// predicted from the command timing rules and compared against monitored outputs.
module tb_glitch_sequencer;

    localparam int RST_CYC = 10;
    localparam int TO      = 100;

    logic       clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_busy = 1'b0, trigger_in = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start, glitch_n, target_rst_n, armed, busy;
    logic [7:0] tx_data;

    glitch_sequencer #(
        .CNT_W(32), .RST_CYCLES(RST_CYC), .TIMEOUT(TO), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .trigger_in(trigger_in), .glitch_n(glitch_n), .target_rst_n(target_rst_n),
        .armed(armed), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitors: transmitted bytes, and the cycle numbers in which each active-low output is low.
    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    int         low_q[$];
    int         trst_q[$];
    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        if (!glitch_n) low_q.push_back(cyc);
        if (!target_rst_n) trst_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        rx_valid = 1'b1;
        rx_data  = b;
        c        = cyc;
        step(1);
        rx_valid = 1'b0;
        step(1);
    endtask

    task automatic load(input logic [7:0] cmd, input logic [31:0] v);
        int c;
        send_byte(cmd, c);
        for (int i = 3; i >= 0; i--) send_byte(v[8*i +: 8], c);
    endtask

    task automatic to_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        tx_q.delete();
        tx_cyc.delete();
        low_q.delete();
        trst_q.delete();
    endtask

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        do b = 8'($urandom);
        while (b inside {8'h44, 8'h57, 8'h41, 8'h46, 8'h52, 8'h58});
        return b;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({glitch_n, target_rst_n, tx_start, armed, busy} !== 5'b11000 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_in: got g=%b t=%b s=%b a=%b b=%b d=%h expected 1 1 0 0 0 00",
                     glitch_n, target_rst_n, tx_start, armed, busy, tx_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3);
        @(negedge clk);
        checks++;
        if ({glitch_n, target_rst_n, tx_start, armed, busy} !== 5'b11000 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_after: got g=%b t=%b s=%b a=%b b=%b d=%h expected 1 1 0 0 0 00",
                     glitch_n, target_rst_n, tx_start, armed, busy, tx_data);
        end
        step(1);
    endtask

    task automatic test_fire();
        logic [31:0] dl[7] = '{5, 88, 0, 0, 0, 0, 0};
        logic [31:0] wd[7] = '{3, 2, 1, 0, 0, 0, 0};
        for (int t = 3; t < 7; t++) begin
            dl[t] = $urandom_range(30, 0);
            wd[t] = $urandom_range(8, 0);
        end
        for (int t = 0; t < 7; t++) begin
            int n;
            bit ok;
            logic [7:0] exp_tx[$];
            int exp_low[$];
            clear_mon();
            load(8'h44, dl[t]);
            load(8'h57, wd[t]);
            send_byte(8'h46, n);
            wait_idle(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL fire_idle[%0d]: busy stuck, expected idle", t); end
            step(12);
            exp_tx = '{8'h44, 8'h57, 8'h46, 8'h47};
            for (int c = n + 1 + int'(dl[t]); c <= n + int'(dl[t]) + int'(wd[t]); c++) exp_low.push_back(c);
            checks++;
            if (tx_q.size() != exp_tx.size()) begin
                errors++;
                $display("FAIL fire_tx_count[%0d]: got %0d expected %0d", t, tx_q.size(), exp_tx.size());
            end else foreach (exp_tx[i]) begin
                checks++;
                if (tx_q[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL fire_tx[%0d][%0d]: got %h expected %h", t, i, tx_q[i], exp_tx[i]);
                end
            end
            checks++;
            if (low_q != exp_low) begin
                errors++;
                $display("FAIL fire_window[%0d] d=%0d w=%0d: got %p expected %p", t, dl[t], wd[t], low_q, exp_low);
            end
        end
    endtask

    task automatic test_trigger();
        for (int t = 0; t < 3; t++) begin
            int d = (t == 0) ? 0 : int'($urandom_range(10, 0));
            int w = (t == 0) ? 1 : int'($urandom_range(4, 1));
            int c, k, n;
            bit ok;
            logic [7:0] exp_tx[$];
            int exp_low[$];
            clear_mon();
            load(8'h44, d);
            load(8'h57, w);
            send_byte(8'h41, c);
            @(negedge clk);
            checks++;
            if (armed !== 1'b1) begin errors++; $display("FAIL trig_armed_on[%0d]: got %b expected 1", t, armed); end
            step(1);
            step($urandom_range(8, 1));
            k = cyc;
            trigger_in = 1'b1;
            n = k + 2;
            to_neg(n);
            checks++;
            if (armed !== 1'b1) begin errors++; $display("FAIL trig_armed_edge[%0d]: got %b expected 1", t, armed); end
            @(negedge clk);
            checks++;
            if (armed !== 1'b0) begin errors++; $display("FAIL trig_armed_off[%0d]: got %b expected 0", t, armed); end
            @(posedge clk);
            #1;
            wait_idle(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL trig_idle[%0d]: busy stuck, expected idle", t); end
            trigger_in = 1'b0;
            step(12);
            exp_tx = '{8'h44, 8'h57, 8'h41, 8'h47};
            for (int x = n + 1 + d; x <= n + d + w; x++) exp_low.push_back(x);
            checks++;
            if (tx_q != exp_tx) begin
                errors++;
                $display("FAIL trig_tx[%0d]: got %p expected %p", t, tx_q, exp_tx);
            end
            checks++;
            if (low_q != exp_low) begin
                errors++;
                $display("FAIL trig_window[%0d] d=%0d w=%0d: got %p expected %p", t, d, w, low_q, exp_low);
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        bit ok;
        logic [7:0] exp_tx[$] = '{8'h41, 8'h54};
        clear_mon();
        send_byte(8'h41, c);
        to_neg(c + TO);
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL timeout_last_armed: got %b expected 1", armed); end
        @(negedge clk);
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL timeout_disarm: got %b expected 0", armed); end
        @(posedge clk);
        #1;
        wait_idle(ok);
        step(12);
        checks++;
        if (tx_q != exp_tx) begin errors++; $display("FAIL timeout_tx: got %p expected %p", tx_q, exp_tx); end
        checks++;
        if (low_q.size() != 0) begin errors++; $display("FAIL timeout_glitch: got %0d low cycles expected 0", low_q.size()); end
    endtask

    task automatic test_trst();
        int n, c;
        bit ok;
        logic [7:0] exp_tx[$] = '{8'h52, 8'h42, 8'h72};
        int exp_low[$];
        clear_mon();
        send_byte(8'h52, n);
        send_byte(8'h46, c);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL trst_idle: busy stuck, expected idle"); end
        step(12);
        for (int x = n + 1; x <= n + RST_CYC; x++) exp_low.push_back(x);
        checks++;
        if (tx_q != exp_tx) begin errors++; $display("FAIL trst_tx: got %p expected %p", tx_q, exp_tx); end
        checks++;
        if (trst_q != exp_low) begin errors++; $display("FAIL trst_window: got %p expected %p", trst_q, exp_low); end
        checks++;
        if (low_q.size() != 0) begin errors++; $display("FAIL trst_glitch: got %0d low cycles expected 0", low_q.size()); end
    endtask

    task automatic test_abort();
        int n, c, k;
        logic [7:0] exp_tx[$];
        clear_mon();
        load(8'h44, 1000);
        load(8'h57, $urandom_range(5, 1));
        send_byte(8'h46, n);
        step(n + 500 - cyc);
        send_byte(8'h58, c);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || c != n + 500) begin
            errors++;
            $display("FAIL abort_delay_busy: got busy=%b at x-cycle %0d expected 0 at %0d", busy, c - n, 500);
        end
        step(13);
        exp_tx = '{8'h44, 8'h57, 8'h46, 8'h58};
        checks++;
        if (tx_q != exp_tx) begin errors++; $display("FAIL abort_delay_tx: got %p expected %p", tx_q, exp_tx); end
        checks++;
        if (low_q.size() != 0) begin errors++; $display("FAIL abort_delay_glitch: got %0d low cycles expected 0", low_q.size()); end

        // Abort in the same cycle as the synchronised trigger edge.
        clear_mon();
        load(8'h44, 0);
        load(8'h57, 2);
        send_byte(8'h41, c);
        step(3);
        k = cyc;
        trigger_in = 1'b1;
        step(2);
        send_byte(8'h58, c);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || c != k + 2) begin
            errors++;
            $display("FAIL abort_edge_busy: got busy=%b x-offset %0d expected 0 offset 2", busy, c - k);
        end
        step(1);
        trigger_in = 1'b0;
        step(12);
        exp_tx = '{8'h44, 8'h57, 8'h41, 8'h58};
        checks++;
        if (tx_q != exp_tx) begin errors++; $display("FAIL abort_edge_tx: got %p expected %p", tx_q, exp_tx); end
        checks++;
        if (low_q.size() != 0) begin errors++; $display("FAIL abort_edge_glitch: got %0d low cycles expected 0", low_q.size()); end
    endtask

    task automatic test_async_reset();
        int n;
        bit ok;
        logic [7:0] exp_tx[$] = '{8'h46, 8'h47};
        load(8'h44, 0);
        load(8'h57, 50);
        send_byte(8'h46, n);
        step(10);
        @(negedge clk);
        checks++;
        if (glitch_n !== 1'b0) begin errors++; $display("FAIL areset_pre: got glitch_n=%b expected 0", glitch_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({glitch_n, target_rst_n, busy} !== 3'b110) begin
            errors++;
            $display("FAIL areset_force: got g=%b t=%b b=%b expected 1 1 0", glitch_n, target_rst_n, busy);
        end
        clear_mon();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(60);
        checks++;
        if (tx_q.size() != 0 || low_q.size() != 0) begin
            errors++;
            $display("FAIL areset_quiet: got %0d tx %0d low expected 0 0", tx_q.size(), low_q.size());
        end
        // Delay and width are back to zero: 'F' answers 'G' with no pulse.
        send_byte(8'h46, n);
        wait_idle(ok);
        step(12);
        checks++;
        if (tx_q != exp_tx) begin errors++; $display("FAIL areset_regs_tx: got %p expected %p", tx_q, exp_tx); end
        checks++;
        if (low_q.size() != 0) begin errors++; $display("FAIL areset_regs_glitch: got %0d low cycles expected 0", low_q.size()); end
    endtask

    task automatic test_back_to_back();
        int c;
        clear_mon();
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(rand_bad(), c);
        step(5);
        checks++;
        if (tx_q.size() != 0) begin errors++; $display("FAIL fifo_hold: got %0d strobes expected 0", tx_q.size()); end
        tx_busy = 1'b0;
        step(20);
        checks++;
        if (tx_q.size() != 4) begin
            errors++;
            $display("FAIL fifo_count: got %0d strobes expected 4", tx_q.size());
        end else begin
            foreach (tx_q[i]) begin
                checks++;
                if (tx_q[i] !== 8'h3F) begin errors++; $display("FAIL fifo_data[%0d]: got %h expected 3f", i, tx_q[i]); end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (tx_cyc[i] - tx_cyc[i-1] < 2) begin
                    errors++;
                    $display("FAIL fifo_gap[%0d]: got gap %0d expected >= 2", i, tx_cyc[i] - tx_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_trigger();
        test_timeout();
        test_trst();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Command-driven sequencer that sits between the UART core and the glitch output pin.
- Parses byte commands from the UART receive side and holds 32-bit delay and width registers.
- Arms on an external target trigger, or fires on command, and drives an exact-length active-low glitch pulse.
- Pulses the target reset line on command.
- Reports every outcome back through the UART transmit side via a small response FIFO.

Parameters:
CNT_W, 32, width of delay, width and timeout counters
RST_CYCLES, 36000000, length of target_rst_n low pulse in clk cycles
TIMEOUT, 72000000, clk cycles to wait in ARMED for a trigger; 0 disables the timeout
RSP_DEPTH, 4, response FIFO entries (power of 2)

Ports:
clk  in  1  system clock (all logic on this clock)
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle strobe: send tx_data
tx_data  out  8  byte to transmit
trigger_in  in  1  asynchronous target trigger, rising edge active
glitch_n  out  1  glitch drive, idle 1, low during glitch
target_rst_n  out  1  target reset, idle 1
armed  out  1  high in ARMED
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: glitch_n=1, target_rst_n=1, tx_start=0, tx_data=0, armed=0, busy=0. Delay and width registers reset to 0. FIFO is emptied. State = IDLE.
- trigger_in passes through a 2-flop synchroniser. A rising edge is detected when sync output is 1 and its previous value was 0.
- States: IDLE, LOAD, ARMED, DELAY, GLITCH, TRST.
- Commands are accepted only in IDLE:
  - 'D' 0x44: enter LOAD. The next 4 bytes form the delay register, big-endian. Ack 'D' after the 4th byte.
  - 'W' 0x57: same as 'D', but loads the width register. Ack 'W'.
  - 'A' 0x41: ack 'A', go to ARMED.
  - 'F' 0x46: ack 'F', go to DELAY.
  - 'R' 0x52: ack 'R', go to TRST.
  - 'X' 0x58 in IDLE: ack 'X', no other effect.
  - Any other byte: respond '?' 0x3F, stay in IDLE.
- In LOAD, every byte (including 0x58) is data. rx_valid has no other effect.
- 'X' in ARMED, DELAY, GLITCH or TRST: abort.
  - Next cycle: glitch_n=1, target_rst_n=1, state IDLE.
  - Respond 'X'. No 'G' is sent.
- Any other byte outside IDLE and LOAD: respond 'B' 0x42, state unchanged.
- ARMED: trigger edge in cycle N goes to DELAY starting at N+1. If TIMEOUT≠0 and TIMEOUT cycles elapse with no edge: respond 'T' 0x54, return to IDLE.
- Timing: with the trigger edge (or 'F' rx_valid) in cycle N, glitch_n is low in cycles N+1+delay through N+delay+width inclusive. That is exactly width cycles. delay=0 means low from N+1.
- width=0: glitch_n never goes low. GLITCH is left immediately and 'G' is still sent.
- End of GLITCH: glitch_n=1 in the same cycle the pulse ends, respond 'G' 0x47, return to IDLE.
- TRST: target_rst_n low for exactly RST_CYCLES cycles, then high, respond 'r' 0x72, return to IDLE.
- Counters are CNT_W bits and compare for equality; there is no wrap within a legal 32-bit range.
- Delay and width are sampled at the DELAY entry. Loads cannot occur while busy.
- Response FIFO:
  - A push occurs in the cycle the response is decided.
  - A pop occurs when non-empty and tx_busy=0 and tx_start was 0 last cycle. tx_start pulses 1 cycle with tx_data = head.
  - Push when full: the new byte is dropped. Pushes on pop cycles succeed.
- Simultaneous events:
  - rx_valid 'X' and a trigger edge in the same cycle in ARMED: abort wins.
  - Trigger edges outside ARMED are ignored.
- Asynchronous reset mid-glitch forces glitch_n=1 and target_rst_n=1 immediately, with no response sent.

Test Plan:
- Send 'D' 00 00 00 05, 'W' 00 00 00 03, 'F' (rx_valid cycle N) -> tx bytes 'D','W','F','G' in order. glitch_n low exactly in cycles N+6..N+8.
- 'A', then a trigger_in rising edge with delay=0 and width=1 -> armed=1 until the edge. One-cycle glitch_n low 1 cycle after the synchronised edge. Tx 'A','G'.
- TIMEOUT=100, 'A', no trigger -> after 100 cycles: armed=0, tx 'T', glitch_n stays 1.
- 'R' with RST_CYCLES=10 -> target_rst_n low exactly 10 cycles. 'F' sent during it yields 'B'. Tx 'R','B','r'.
- Delay=1000, 'F', then 'X' at cycle 500 -> glitch_n never low. Tx 'F','X' with no 'G'.
- Hold tx_busy=1 and send 6 invalid bytes -> 4 '?' queued. Release tx_busy -> exactly 4 tx_start strobes, none back-to-back.
